// File: rtl/ysyx_2022040010_sram_arb.sv
// Shares one single-port memory channel between fetch (isram) and data (dsram) ports; data wins unless YSYX_2022040010_ARB_RR_EN selects round-robin.
// Latency: 4 cycles from request to ok with an immediate ready/rvalid; each stalled ready/rvalid cycle adds one.
// Backpressure: mem_req holds with stable fields until mem_ready; stallreq_for_mem freezes the pipeline until every enabled port is done.
module ysyx_2022040010_sram_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        isram_e,
    input  logic [63:0] isram_addr,
    output logic [31:0] isram_rdata,
    output logic        isram_ok,
    input  logic        dsram_e,
    input  logic        dsram_we,
    input  logic [63:0] dsram_addr,
    input  logic [63:0] dsram_wdata,
    input  logic [7:0]  dsram_sel,
    output logic [63:0] dsram_rdata,
    output logic        dsram_ok,
    output logic        stallreq_for_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_sel,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_nxt;
    logic   i_done, d_done;
    logic   gnt_d;
    logic   pending_i, pending_d;
    logic   grant_vld, pick_d;
`ifdef YSYX_2022040010_ARB_RR_EN
    logic   last_fetch;
`endif

    assign pending_i        = isram_e & ~i_done;
    assign pending_d        = dsram_e & ~d_done;
    assign stallreq_for_mem = ~rst & (pending_i | pending_d);
    assign mem_req          = (state == REQ);
    assign isram_ok         = i_done;
    assign dsram_ok         = d_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
`ifdef YSYX_2022040010_ARB_RR_EN
        // On conflict, the port that was not served last goes first.
        pick_d    = pending_d & (~pending_i | last_fetch);
`else
        pick_d    = pending_d;
`endif
        case (state)
            IDLE: if (pending_i | pending_d) begin
                grant_vld = 1'b1;
                state_nxt = REQ;
            end
            REQ:  if (mem_ready)  state_nxt = WAIT;
            WAIT: if (mem_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_d       <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_sel     <= '0;
            isram_rdata <= '0;
            dsram_rdata <= '0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
`ifdef YSYX_2022040010_ARB_RR_EN
            last_fetch  <= 1'b0;
`endif
        end else begin
            if (grant_vld) begin
                gnt_d     <= pick_d;
                mem_we    <= pick_d & dsram_we;
                mem_addr  <= pick_d ? dsram_addr  : isram_addr;
                mem_wdata <= pick_d ? dsram_wdata : 64'd0;
                mem_sel   <= pick_d ? dsram_sel   : 8'hFF;
`ifdef YSYX_2022040010_ARB_RR_EN
                last_fetch <= ~pick_d;
`endif
            end
            if (state == WAIT && mem_rvalid) begin
                if (gnt_d) begin
                    if (!mem_we) dsram_rdata <= mem_rdata;
                end else begin
                    isram_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                end
            end
            // The pipeline advances whenever no stall is raised, so completion is forgotten then.
            if (!stallreq_for_mem) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end else if (state == DONE) begin
                if (gnt_d) d_done <= 1'b1;
                else       i_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_sram_arb.sv
// Directed bench for ysyx_2022040010_sram_arb: fetch, store with backpressure, fetch+load conflict, reset mid-transaction.
module tb_ysyx_2022040010_sram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        isram_e;
    logic [63:0] isram_addr;
    logic [31:0] isram_rdata;
    logic        isram_ok;
    logic        dsram_e;
    logic        dsram_we;
    logic [63:0] dsram_addr;
    logic [63:0] dsram_wdata;
    logic [7:0]  dsram_sel;
    logic [63:0] dsram_rdata;
    logic        dsram_ok;
    logic        stallreq_for_mem;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_sel;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && mem_req && mem_ready) hs_cnt <= hs_cnt + 1;

    ysyx_2022040010_sram_arb dut (
        .clk(clk), .rst(rst),
        .isram_e(isram_e), .isram_addr(isram_addr), .isram_rdata(isram_rdata), .isram_ok(isram_ok),
        .dsram_e(dsram_e), .dsram_we(dsram_we), .dsram_addr(dsram_addr), .dsram_wdata(dsram_wdata),
        .dsram_sel(dsram_sel), .dsram_rdata(dsram_rdata), .dsram_ok(dsram_ok),
        .stallreq_for_mem(stallreq_for_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hs0;

    initial begin
        rst = 1'b1;
        isram_e = 0; isram_addr = '0;
        dsram_e = 0; dsram_we = 0; dsram_addr = '0; dsram_wdata = '0; dsram_sel = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        tick(); tick();
        check("rst_stall", stallreq_for_mem, 0);
        rst = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_sel", mem_sel, 0);
        check("rst_isram_rdata", isram_rdata, 0);
        check("rst_dsram_rdata", dsram_rdata, 0);
        check("rst_ok", {isram_ok, dsram_ok}, 0);

        // Idle with no enables
        tick();
        check("idle_stall", stallreq_for_mem, 0);
        check("idle_req", mem_req, 0);

        // Single fetch, immediate handshakes
        isram_e = 1; isram_addr = 64'h8000_0004;
        #1;
        check("f_c0_stall", stallreq_for_mem, 1);
        tick();
        check("f_c1_req", mem_req, 1);
        check("f_c1_addr", mem_addr, 64'h8000_0004);
        check("f_c1_sel", mem_sel, 8'hFF);
        check("f_c1_we", mem_we, 0);
        mem_ready = 1;
        tick();
        check("f_c2_req", mem_req, 0);
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        mem_rvalid = 0;
        check("f_c3_stall", stallreq_for_mem, 1);
        check("f_c3_ok", isram_ok, 0);
        tick();
        check("f_c4_ok", isram_ok, 1);
        check("f_c4_stall", stallreq_for_mem, 0);
        check("f_c4_rdata", isram_rdata, 32'h1111_2222);
        isram_e = 0;
        tick();
        check("f_c5_ok_clear", isram_ok, 0);

        // Store with 3 cycles of mem_ready low
        dsram_e = 1; dsram_we = 1; dsram_addr = 64'h8000_1000;
        dsram_wdata = 64'h0000_0000_DEAD_BEEF; dsram_sel = 8'h0F;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("s_req_held", mem_req, 1);
            check("s_addr", mem_addr, 64'h8000_1000);
            check("s_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
            tick();
        end
        check("s_req_4th", mem_req, 1);
        check("s_we", mem_we, 1);
        check("s_sel", mem_sel, 8'h0F);
        mem_ready = 1;
        tick();
        check("s_wait_req", mem_req, 0);
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rvalid = 0;
        check("s_done_ok", dsram_ok, 0);
        tick();
        check("s_ok", dsram_ok, 1);
        check("s_stall", stallreq_for_mem, 0);
        check("s_rdata_kept", dsram_rdata, 0);
        dsram_e = 0; dsram_we = 0;
        tick();

        // Fetch and load together
        hs0 = hs_cnt;
        isram_e = 1; isram_addr = 64'h8000_0000;
        dsram_e = 1; dsram_we = 0; dsram_addr = 64'h8000_2008; dsram_sel = 8'hFF;
        tick();
`ifdef YSYX_2022040010_ARB_RR_EN
        check("c_first_addr", mem_addr, 64'h8000_0000);
`else
        check("c_first_addr", mem_addr, 64'h8000_2008);
`endif
        mem_ready = 1;
        tick();
        mem_ready = 0; mem_rvalid = 1;
`ifdef YSYX_2022040010_ARB_RR_EN
        mem_rdata = 64'h5555_6666_7777_8888;
`else
        mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
`endif
        tick();
        mem_rvalid = 0;
        tick();
        check("c_c4_stall", stallreq_for_mem, 1);
`ifdef YSYX_2022040010_ARB_RR_EN
        check("c_c4_ok", {isram_ok, dsram_ok}, 2'b10);
`else
        check("c_c4_ok", {isram_ok, dsram_ok}, 2'b01);
`endif
        tick();
        check("c_c5_req", mem_req, 1);
`ifdef YSYX_2022040010_ARB_RR_EN
        check("c_second_addr", mem_addr, 64'h8000_2008);
`else
        check("c_second_addr", mem_addr, 64'h8000_0000);
`endif
        mem_ready = 1;
        tick();
        mem_ready = 0; mem_rvalid = 1;
`ifdef YSYX_2022040010_ARB_RR_EN
        mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
`else
        mem_rdata = 64'h5555_6666_7777_8888;
`endif
        tick();
        mem_rvalid = 0;
        check("c_c7_stall", stallreq_for_mem, 1);
        tick();
        check("c_c8_stall", stallreq_for_mem, 0);
        check("c_c8_ok", {isram_ok, dsram_ok}, 2'b11);
        check("c_irdata", isram_rdata, 32'h7777_8888);
        check("c_drdata", dsram_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        isram_e = 0; dsram_e = 0;
        tick();
        check("c_no_repeat", mem_req, 0);
        check("c_hs_count", hs_cnt - hs0, 2);

        // Reset while in WAIT, then a late rvalid
        isram_e = 1; isram_addr = 64'h8000_0010;
        tick();
        mem_ready = 1;
        tick();
        mem_ready = 0;
        rst = 1;
        #1;
        check("r_stall_in_rst", stallreq_for_mem, 0);
        tick();
        rst = 0; isram_e = 0;
        check("r_req", mem_req, 0);
        check("r_addr", mem_addr, 0);
        mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        tick();
        mem_rvalid = 0;
        check("r_rdata", isram_rdata, 0);
        check("r_ok", {isram_ok, dsram_ok}, 0);
        check("r_idle", mem_req, 0);
        check("r_stall", stallreq_for_mem, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
